// File: rtl/rocket_pkg.sv
// rocket_pkg
//   Shared types and defaults for the rocket pool controller.
//   - slot_state_t : per-slot FSM state encoding
//   - COORD_W      : width of pixel coordinates and speeds (signed)
//   - *_DEF        : default fixed-point and screen geometry parameters
package rocket_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_t;

  localparam int COORD_W      = 11;
  localparam int FRAC_BITS_DEF = 6;
  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;
  localparam int ROCKET_W_DEF  = 4;
  localparam int ROCKET_H_DEF  = 10;

  // Accumulator width: pixel bits + fraction + two guard bits for overshoot.
  function automatic int acc_width(input int frac_bits);
    return COORD_W + frac_bits + 2;
  endfunction

endpackage

// File: rtl/rocket_slot.sv
// rocket_slot
//   One projectile: FSM, fixed-point position accumulator and border check.
//   Ports:
//     clk, resetN   : clock, async active-low reset
//     load          : launch this slot (honoured only while IDLE)
//     hit           : external kill (honoured only while FLYING)
//     startOfFrame  : frame tick; advance or retire on the border
//     posIn         : {Y, X} launch position in pixels, signed
//     speedIn       : {Y, X} speed in 1/2^FRAC_BITS px per frame, signed
//     active        : slot is FLYING
//     topLeft       : {Y, X} current pixel position, signed
//     borderPulse   : one-cycle pulse when the slot retires on the border
//
//   state  | meaning
//   IDLE   | free; holds last position, waits for load
//   FLYING | moving each frame until hit or out of bounds
module rocket_slot
  import rocket_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int ROCKET_W  = ROCKET_W_DEF,
  parameter int ROCKET_H  = ROCKET_H_DEF
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   load,
  input  logic                   hit,
  input  logic                   startOfFrame,
  input  logic [2*COORD_W-1:0]   posIn,
  input  logic [2*COORD_W-1:0]   speedIn,
  output logic                   active,
  output logic [2*COORD_W-1:0]   topLeft,
  output logic                   borderPulse
);

  localparam int ACC_W = acc_width(FRAC_BITS);
  localparam int EXT_W = ACC_W - COORD_W;

  localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - ROCKET_W);
  localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - ROCKET_H);

  slot_state_t               r_state;
  logic signed [ACC_W-1:0]   r_accX, r_accY;
  logic signed [COORD_W-1:0] r_spdX, r_spdY;
  logic                      r_border;

  logic signed [COORD_W-1:0] w_pixX, w_pixY;
  logic                      w_oob;

  // Arithmetic shift by FRAC_BITS then truncation to COORD_W is a plain slice.
  assign w_pixX = r_accX[FRAC_BITS +: COORD_W];
  assign w_pixY = r_accY[FRAC_BITS +: COORD_W];

  assign w_oob = (w_pixX < 0) || (w_pixX > X_MAX) ||
                 (w_pixY < 0) || (w_pixY > Y_MAX);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_accX   <= '0;
      r_accY   <= '0;
      r_spdX   <= '0;
      r_spdY   <= '0;
      r_border <= 1'b0;
    end else begin
      r_border <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_state <= FLYING;
            r_accX  <= {{2{posIn[COORD_W-1]}}, posIn[COORD_W-1:0], {FRAC_BITS{1'b0}}};
            r_accY  <= {{2{posIn[2*COORD_W-1]}}, posIn[2*COORD_W-1:COORD_W], {FRAC_BITS{1'b0}}};
            r_spdX  <= speedIn[COORD_W-1:0];
            r_spdY  <= speedIn[2*COORD_W-1:COORD_W];
          end
        end
        FLYING: begin
          // A hit in the same cycle as the frame tick wins: no border pulse.
          if (hit) begin
            r_state <= IDLE;
          end else if (startOfFrame) begin
            if (w_oob) begin
              r_state  <= IDLE;
              r_border <= 1'b1;
            end else begin
              r_accX <= r_accX + {{EXT_W{r_spdX[COORD_W-1]}}, r_spdX};
              r_accY <= r_accY + {{EXT_W{r_spdY[COORD_W-1]}}, r_spdY};
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign active      = (r_state == FLYING);
  assign topLeft     = {w_pixY, w_pixX};
  assign borderPulse = r_border;

endmodule

// File: rtl/rocket_pool_controller.sv
// rocket_pool_controller
//   Pool of NUM_ROCKETS projectile slots sharing one fire request port.
//   Ports:
//     clk, resetN             : clock, async active-low reset
//     startOfFrame            : one-cycle frame pulse
//     fireReq                 : level launch request
//     fireX/Y, fireSpeedX/Y   : launch position (px) and speed, signed 11-bit
//     fireAck                 : one-cycle pulse on an accepted shot
//     poolFull, coolingDown   : acceptance blockers
//     hitClear                : per-slot kill
//     rocketActive            : per-slot FLYING flag
//     topLeftX/Y              : per-slot packed pixel position, slot i at [11i+10:11i]
//     borderPulse             : per-slot border retire pulse
module rocket_pool_controller
  import rocket_pkg::*;
#(
  parameter int NUM_ROCKETS     = 4,
  parameter int FRAC_BITS       = FRAC_BITS_DEF,
  parameter int SCREEN_W        = SCREEN_W_DEF,
  parameter int SCREEN_H        = SCREEN_H_DEF,
  parameter int ROCKET_W        = ROCKET_W_DEF,
  parameter int ROCKET_H        = ROCKET_H_DEF,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             startOfFrame,
  input  logic                             fireReq,
  input  logic signed [COORD_W-1:0]        fireX,
  input  logic signed [COORD_W-1:0]        fireY,
  input  logic signed [COORD_W-1:0]        fireSpeedX,
  input  logic signed [COORD_W-1:0]        fireSpeedY,
  output logic                             fireAck,
  output logic                             poolFull,
  output logic                             coolingDown,
  input  logic [NUM_ROCKETS-1:0]           hitClear,
  output logic [NUM_ROCKETS-1:0]           rocketActive,
  output logic [NUM_ROCKETS*COORD_W-1:0]   topLeftX,
  output logic [NUM_ROCKETS*COORD_W-1:0]   topLeftY,
  output logic [NUM_ROCKETS-1:0]           borderPulse
);

  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  logic [CD_W-1:0]        r_cooldown;
  logic                   r_fireAck;
  logic [NUM_ROCKETS-1:0] w_active;
  logic [NUM_ROCKETS-1:0] w_idle;
  logic [NUM_ROCKETS-1:0] w_grant;
  logic [NUM_ROCKETS-1:0] w_load;
  logic                   w_full;
  logic                   w_cooling;
  logic                   w_accept;

  assign w_idle    = ~w_active;
  assign w_full    = &w_active;
  assign w_cooling = (r_cooldown != '0);
  assign w_accept  = fireReq && !w_full && !w_cooling;

  // Isolate the lowest set bit of the idle mask: lowest-index free slot.
  assign w_grant = w_idle & (~w_idle + NUM_ROCKETS'(1));
  assign w_load  = w_accept ? w_grant : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cooldown <= '0;
      r_fireAck  <= 1'b0;
    end else begin
      r_fireAck <= w_accept;
      // A launch in a frame-tick cycle reloads without decrementing.
      if (w_accept) begin
        r_cooldown <= CD_W'(COOLDOWN_FRAMES);
      end else if (startOfFrame && w_cooling) begin
        r_cooldown <= r_cooldown - CD_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_ROCKETS; i++) begin : g_slot
    logic [2*COORD_W-1:0] w_topLeft;

    rocket_slot #(
      .FRAC_BITS (FRAC_BITS),
      .SCREEN_W  (SCREEN_W),
      .SCREEN_H  (SCREEN_H),
      .ROCKET_W  (ROCKET_W),
      .ROCKET_H  (ROCKET_H)
    ) u_slot (
      .clk          (clk),
      .resetN       (resetN),
      .load         (w_load[i]),
      .hit          (hitClear[i]),
      .startOfFrame (startOfFrame),
      .posIn        ({fireY, fireX}),
      .speedIn      ({fireSpeedY, fireSpeedX}),
      .active       (w_active[i]),
      .topLeft      (w_topLeft),
      .borderPulse  (borderPulse[i])
    );

    assign topLeftX[i*COORD_W +: COORD_W] = w_topLeft[COORD_W-1:0];
    assign topLeftY[i*COORD_W +: COORD_W] = w_topLeft[2*COORD_W-1:COORD_W];
  end

  assign rocketActive = w_active;
  assign poolFull     = w_full;
  assign coolingDown  = w_cooling;
  assign fireAck      = r_fireAck;

endmodule
